// File: rtl/barrel_shifter_pipe.sv
// Pipelined shift/rotate unit with valid/ready flow control.
// One register slice per log2 move; the whole pipe stalls together on back-pressure.
module barrel_shifter_pipe #(
    parameter  int unsigned BW_DATA = 8,
    localparam int unsigned BW_CTRL = $clog2(BW_DATA)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_CTRL-1:0] i_k,
    input  logic               i_left,
    input  logic [1:0]         i_mode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_y,
    output logic               o_zero
);

    localparam int unsigned BW_DBL = 2 * BW_DATA;

    logic               en;

    logic [BW_DATA-1:0] data_q  [BW_CTRL];
    logic               valid_q [BW_CTRL];
    logic [BW_CTRL-1:0] k_q     [BW_CTRL];
    logic               left_q  [BW_CTRL];
    logic [1:0]         mode_q  [BW_CTRL];
    logic               sign_q  [BW_CTRL];

    logic [BW_DATA-1:0] in_data  [BW_CTRL];
    logic               in_valid [BW_CTRL];
    logic [BW_CTRL-1:0] in_k     [BW_CTRL];
    logic               in_left  [BW_CTRL];
    logic [1:0]         in_mode  [BW_CTRL];
    logic               in_sign  [BW_CTRL];
    logic [BW_DATA-1:0] nxt_data [BW_CTRL];

    // Single fixed-distance move; mode 11 falls into the logical branch.
    function automatic logic [BW_DATA-1:0] move_by(
        input logic [BW_DATA-1:0] d,
        input int unsigned        amt,
        input logic               left,
        input logic [1:0]         mode,
        input logic               sign
    );
        logic [BW_DBL-1:0]  wide;
        logic [BW_DATA-1:0] r;
        wide = '0;
        r    = d;
        case (mode)
            2'b00: begin
                if (left) begin
                    wide = {d, d} << amt;
                    r    = wide[BW_DBL-1:BW_DATA];
                end else begin
                    wide = {d, d} >> amt;
                    r    = wide[BW_DATA-1:0];
                end
            end
            2'b10: begin
                if (left) begin
                    r = d << amt;
                end else begin
                    wide = {{BW_DATA{sign}}, d} >> amt;
                    r    = wide[BW_DATA-1:0];
                end
            end
            default: r = left ? (d << amt) : (d >> amt);
        endcase
        return r;
    endfunction

    assign en      = ~o_valid | i_ready;
    assign o_ready = en;
    assign o_valid = valid_q[BW_CTRL-1];
    assign o_y     = data_q[BW_CTRL-1];
    assign o_zero  = ~|o_y;

    // Stage 0 takes the ports; later stages take the previous slice.
    always_comb begin
        in_data[0]  = i_a;
        in_valid[0] = i_valid;
        in_k[0]     = i_k;
        in_left[0]  = i_left;
        in_mode[0]  = i_mode;
        in_sign[0]  = i_a[BW_DATA-1];
        for (int unsigned s = 1; s < BW_CTRL; s++) begin
            in_data[s]  = data_q[s-1];
            in_valid[s] = valid_q[s-1];
            in_k[s]     = k_q[s-1];
            in_left[s]  = left_q[s-1];
            in_mode[s]  = mode_q[s-1];
            in_sign[s]  = sign_q[s-1];
        end
        for (int unsigned s = 0; s < BW_CTRL; s++) begin
            nxt_data[s] = in_data[s];
            if (in_k[s][BW_CTRL-1-s]) begin
                nxt_data[s] = move_by(in_data[s], 1 << (BW_CTRL-1-s),
                                      in_left[s], in_mode[s], in_sign[s]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned s = 0; s < BW_CTRL; s++) begin
                data_q[s]  <= '0;
                valid_q[s] <= 1'b0;
                k_q[s]     <= '0;
                left_q[s]  <= 1'b0;
                mode_q[s]  <= 2'b00;
                sign_q[s]  <= 1'b0;
            end
        end else if (en) begin
            for (int unsigned s = 0; s < BW_CTRL; s++) begin
                data_q[s]  <= nxt_data[s];
                valid_q[s] <= in_valid[s];
                k_q[s]     <= in_k[s];
                left_q[s]  <= in_left[s];
                mode_q[s]  <= in_mode[s];
                sign_q[s]  <= in_sign[s];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at widths 8, 32 and 2.
module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       v8, r8, l8, ov8, ir8, z8;
    logic [7:0] a8, y8;
    logic [2:0] k8;
    logic [1:0] m8;

    logic        v32, r32, l32, ov32, ir32, z32;
    logic [31:0] a32, y32;
    logic [4:0]  k32;
    logic [1:0]  m32;

    logic       v2, r2, l2, ov2, ir2, z2;
    logic [1:0] a2, y2;
    logic [0:0] k2;
    logic [1:0] m2;

    barrel_shifter_pipe #(.BW_DATA(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(r8), .i_a(a8), .i_k(k8),
        .i_left(l8), .i_mode(m8), .o_valid(ov8), .i_ready(ir8), .o_y(y8), .o_zero(z8)
    );
    barrel_shifter_pipe #(.BW_DATA(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(r32), .i_a(a32), .i_k(k32),
        .i_left(l32), .i_mode(m32), .o_valid(ov32), .i_ready(ir32), .o_y(y32), .o_zero(z32)
    );
    barrel_shifter_pipe #(.BW_DATA(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(r2), .i_a(a2), .i_k(k2),
        .i_left(l2), .i_mode(m2), .o_valid(ov2), .i_ready(ir2), .o_y(y2), .o_zero(z2)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;

    logic [31:0] q8[$];
    logic [31:0] q32[$];
    logic [31:0] q2[$];

    logic        hold_p [3];
    logic [31:0] y_p    [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int w);
        return (w == 0) ? 8 : ((w == 1) ? 32 : 2);
    endfunction

    // Behavioural reference, computed on the low w bits of a 32-bit word.
    function automatic logic [31:0] model(input logic [31:0] a_in, input int k, input logic l,
                                          input logic [1:0] m, input int w);
        logic [31:0] mask, a, r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a    = a_in & mask;
        if (k == 0) return a;
        case (m)
            2'b00: r = l ? ((a << k) | (a >> (w - k))) : ((a >> k) | (a << (w - k)));
            2'b10: begin
                if (l) r = a << k;
                else begin
                    r = a >> k;
                    if (a[w-1]) r = r | (mask & ~(mask >> k));
                end
            end
            default: r = l ? (a << k) : (a >> k);
        endcase
        return r & mask;
    endfunction

    task automatic set_in(input int w, input logic v, input logic [31:0] a, input int k,
                          input logic l, input logic [1:0] m);
        case (w)
            0: begin v8 = v; a8 = a[7:0]; k8 = 3'(k); l8 = l; m8 = m; end
            1: begin v32 = v; a32 = a; k32 = 5'(k); l32 = l; m32 = m; end
            default: begin v2 = v; a2 = a[1:0]; k2 = 1'(k); l2 = l; m2 = m; end
        endcase
    endtask

    task automatic set_iready(input int w, input logic r);
        case (w)
            0: ir8 = r;
            1: ir32 = r;
            default: ir2 = r;
        endcase
    endtask

    function automatic logic get_ready(input int w);
        return (w == 0) ? r8 : ((w == 1) ? r32 : r2);
    endfunction

    task automatic push(input int w, input logic [31:0] e);
        case (w)
            0: q8.push_back(e);
            1: q32.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int w);
        return (w == 0) ? q8.size() : ((w == 1) ? q32.size() : q2.size());
    endfunction

    task automatic pop(input int w, output logic [31:0] e);
        case (w)
            0: e = q8.pop_front();
            1: e = q32.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic snap(input int w, output logic vld, output logic [31:0] y, output logic z,
                        output logic rdy, output logic ird);
        case (w)
            0: begin vld = ov8; y = {24'd0, y8}; z = z8; rdy = r8; ird = ir8; end
            1: begin vld = ov32; y = y32; z = z32; rdy = r32; ird = ir32; end
            default: begin vld = ov2; y = {30'd0, y2}; z = z2; rdy = r2; ird = ir2; end
        endcase
    endtask

    // Output side: handshake compare, hold stability, ready relation.
    logic        m_vld, m_z, m_rdy, m_ird;
    logic [31:0] m_y, m_e;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int w = 0; w < 3; w++) begin
                snap(w, m_vld, m_y, m_z, m_rdy, m_ird);
                chk($sformatf("ready_rel_w%0d", width_of(w)), {31'd0, m_rdy},
                    {31'd0, ~(m_vld & ~m_ird)});
                if (hold_p[w]) begin
                    chk($sformatf("hold_valid_w%0d", width_of(w)), {31'd0, m_vld}, 32'd1);
                    chk($sformatf("hold_y_w%0d", width_of(w)), m_y, y_p[w]);
                end
                if (m_vld && m_ird) begin
                    if (qsize(w) == 0) begin
                        chk($sformatf("spurious_valid_w%0d", width_of(w)), {31'd0, m_vld}, 32'd0);
                    end else begin
                        pop(w, m_e);
                        chk($sformatf("result_w%0d", width_of(w)), m_y, m_e);
                        chk($sformatf("zero_w%0d", width_of(w)), {31'd0, m_z},
                            {31'd0, (m_e == 32'd0)});
                    end
                end
                hold_p[w] = !rst && m_vld && !m_ird;
                y_p[w]    = m_y;
            end
        end
    end

    // Present one transaction and hold it until accepted.
    task automatic drive(input int w, input logic [31:0] a, input int k, input logic l,
                         input logic [1:0] m, input logic [31:0] e);
        logic rdy;
        bit   done;
        done = 1'b0;
        rdy  = 1'b0;
        set_in(w, 1'b1, a, k, l, m);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            rdy = get_ready(w);
            if (rdy) begin
                push(w, e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) set_iready(w, 1'($urandom_range(0, 1)));
        end
        set_in(w, 1'b0, a, k, l, m);
        if (!done) chk($sformatf("accept_timeout_w%0d", width_of(w)), {31'd0, rdy}, 32'd1);
    endtask

    task automatic drain();
        ir8 = 1'b1; ir32 = 1'b1; ir2 = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (qsize(0) + qsize(1) + qsize(2) == 0) break;
        end
        @(posedge clk);
        #1;
        chk("drain_left", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);
    endtask

    // 8-bit transaction with exact-latency observation; call at posedge+1.
    task automatic lat_test(input logic [7:0] a, input int k, input logic l,
                            input logic [1:0] m, input logic [7:0] e);
        set_in(0, 1'b1, {24'd0, a}, k, l, m);
        @(negedge clk);
        chk("lat_accept_ready", {31'd0, r8}, 32'd1);
        push(0, {24'd0, e});
        @(posedge clk);
        #1;
        set_in(0, 1'b0, {24'd0, a}, k, l, m);
        @(negedge clk);
        chk("lat_valid_c1", {31'd0, ov8}, 32'd0);
        @(negedge clk);
        chk("lat_valid_c2", {31'd0, ov8}, 32'd0);
        @(negedge clk);
        chk("lat_valid_c3", {31'd0, ov8}, 32'd1);
        chk("lat_y_c3", {24'd0, y8}, {24'd0, e});
        chk("lat_zero_c3", {31'd0, z8}, {31'd0, (e == 8'd0)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        int          rk;
        logic        rl;
        logic [1:0]  rm;

        for (int w = 0; w < 3; w++) begin
            hold_p[w] = 1'b0;
            y_p[w]    = 32'd0;
            set_in(w, 1'b0, 32'd0, 0, 1'b0, 2'b00);
            set_iready(w, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, ov8}, 32'd0);
        chk("rst_y", {24'd0, y8}, 32'd0);
        chk("rst_zero", {31'd0, z8}, 32'd1);
        chk("rst_ready", {31'd0, r8}, 32'd1);
        chk("rst_valid_w32", {31'd0, ov32}, 32'd0);
        chk("rst_valid_w2", {31'd0, ov2}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        lat_test(8'b1001_0110, 3, 1'b1, 2'b00, 8'b1011_0100);
        drain();

        drive(0, 32'h90, 2, 1'b0, 2'b10, 32'hE4);
        drive(0, 32'h90, 2, 1'b0, 2'b01, 32'h24);
        drive(0, 32'h90, 2, 1'b0, 2'b11, 32'h24);
        drive(0, 32'h81, 7, 1'b1, 2'b01, 32'h80);
        drive(0, 32'h01, 1, 1'b0, 2'b01, 32'h00);
        drive(0, 32'hF0, 4, 1'b0, 2'b10, 32'hFF);
        drive(0, 32'h70, 4, 1'b0, 2'b10, 32'h07);
        drive(0, 32'h81, 1, 1'b0, 2'b00, 32'hC0);
        for (int m = 0; m < 4; m++) begin
            drive(0, 32'hA5, 0, 1'b1, 2'(m), 32'hA5);
            drive(0, 32'hA5, 0, 1'b0, 2'(m), 32'hA5);
        end
        drain();

        rand_rdy = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int n = 0; n < 24; n++) begin
                ra = $urandom;
                rk = int'($urandom_range(0, width_of(w) - 1));
                rl = 1'($urandom_range(0, 1));
                rm = 2'($urandom_range(0, 3));
                drive(w, ra, rk, rl, rm, model(ra, rk, rl, rm, width_of(w)));
            end
        end
        rand_rdy = 1'b0;
        drain();

        drive(0, 32'h11, 1, 1'b1, 2'b01, 32'h22);
        drive(0, 32'h22, 1, 1'b1, 2'b01, 32'h44);
        drive(0, 32'h44, 1, 1'b1, 2'b01, 32'h88);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("midrst_valid", {31'd0, ov8}, 32'd0);
        chk("midrst_y", {24'd0, y8}, 32'd0);
        chk("midrst_zero", {31'd0, z8}, 32'd1);
        chk("midrst_ready", {31'd0, r8}, 32'd1);
        @(posedge clk);
        #1;
        lat_test(8'h3C, 2, 1'b0, 2'b00, 8'h0F);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
